// File: rtl/unified_memory_pkg.sv
// unified_memory_pkg: FSM states, access-size codes and alignment helpers for unified_memory.
package unified_memory_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, EXEC, DATA} state_t;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  function automatic logic misaligned(logic [1:0] size, logic [1:0] a);
    return size == SZ_BYTE ? 1'b0 : size == SZ_HALF ? a[0] : |a;
  endfunction
  function automatic logic [1:0] force_align(logic [1:0] size, logic [1:0] a);
    return size == SZ_BYTE ? a : size == SZ_HALF ? {a[1], 1'b0} : 2'b00;
  endfunction
endpackage

// File: rtl/unified_memory_if.sv
// unified_memory_if: control-unit/datapath handshake and bus signals of the unified memory.
interface unified_memory_if;
  logic        Start, Step, Mem_Req, S, Unsigned, E, Busy, Done, Fault;
  logic [1:0]  Size;
  logic [31:0] Next_PC, Data_Addr, Data_In, PC_out, Iout, Mout;
  modport master(output Start, Next_PC, Step, Mem_Req, S, Size, Unsigned, Data_Addr, Data_In,
                 input PC_out, Iout, Mout, E, Busy, Done, Fault);
  modport slave(input Start, Next_PC, Step, Mem_Req, S, Size, Unsigned, Data_Addr, Data_In,
                output PC_out, Iout, Mout, E, Busy, Done, Fault);
endinterface

// File: rtl/unified_memory_mem_lane_align.sv
// mem_lane_align: little-endian byte-lane write mask/merge and extended load extraction.
module mem_lane_align
  import unified_memory_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        unsigned_ext,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  wmask,
  output logic [31:0] wword,
  output logic [31:0] rdata_ext
);
  logic [31:0] wsrc, sh;
  assign wmask = size == SZ_BYTE ? 4'b0001 << addr : size == SZ_HALF ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign wsrc = size == SZ_BYTE ? {4{wdata[7:0]}} : size == SZ_HALF ? {2{wdata[15:0]}} : wdata;
  for (genvar i = 0; i < 4; i++) begin : g_lane
    assign wword[8*i +: 8] = wmask[i] ? wsrc[8*i +: 8] : rdata[8*i +: 8];
  end
  assign sh = rdata >> {addr, 3'b000};
  assign rdata_ext = size == SZ_BYTE ? {{24{~unsigned_ext & sh[7]}}, sh[7:0]} :
                     size == SZ_HALF ? {{16{~unsigned_ext & sh[15]}}, sh[15:0]} : rdata;
endmodule

// File: rtl/unified_memory.sv
// unified_memory: shared instruction/data RAM sequenced as FETCH -> EXEC -> optional DATA with wait states.
// Define UNIFIED_MEM_ALIGN_CHECK_EN to fault on misaligned accesses instead of force-aligning them.
module unified_memory
  import unified_memory_pkg::*;
#(
  parameter int          DEPTH       = 256,
  parameter int          WAIT_CYCLES = 0,
  parameter logic [31:0] RESET_PC    = 32'h0
) (
  input logic             Clock,
  input logic             Reset_n,
  unified_memory_if.slave b
);
  localparam int AW = $clog2(DEPTH);
  state_t          st, nxt;
  logic [3:0]      cnt, wmask;
  logic [31:0]     mem [DEPTH];
  logic [31:0]     pc, iout, mout, din_q, rword, wword, ld;
  logic [AW+1:0]   addr_q;
  logic [1:0]      size_q, a_lo;
  logic            s_q, uns_q, done, done_nx, fault, wait_done, fetch_bad, data_bad, wr_en;
  assign wait_done = cnt == 4'(WAIT_CYCLES);
`ifdef UNIFIED_MEM_ALIGN_CHECK_EN
  assign fetch_bad = |pc[1:0];
  assign data_bad  = misaligned(size_q, addr_q[1:0]);
  assign a_lo      = addr_q[1:0];
`else
  assign fetch_bad = 1'b0;
  assign data_bad  = 1'b0;
  assign a_lo      = force_align(size_q, addr_q[1:0]);
`endif
  assign rword = mem[addr_q[AW+1:2]];
  mem_lane_align u_align (
    .size(size_q), .unsigned_ext(uns_q), .addr(a_lo), .wdata(din_q), .rdata(rword),
    .wmask(wmask), .wword(wword), .rdata_ext(ld)
  );
  assign wr_en = st == DATA && wait_done && s_q && !data_bad;
  always_comb begin
    nxt = st;
    done_nx = 1'b0;
    case (st)
      IDLE:  nxt = b.Start ? FETCH : IDLE;
      FETCH: begin
        nxt = !wait_done ? FETCH : fetch_bad ? IDLE : EXEC;
        done_nx = wait_done && fetch_bad;
      end
      EXEC: begin
        nxt = !b.Step ? EXEC : b.Mem_Req ? DATA : IDLE;
        done_nx = b.Step && !b.Mem_Req;
      end
      default: begin
        nxt = wait_done ? IDLE : DATA;
        done_nx = wait_done;
      end
    endcase
  end
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) st <= IDLE;
    else st <= nxt;
  end
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt    <= '0;
      pc     <= RESET_PC;
      iout   <= '0;
      mout   <= '0;
      done   <= 1'b0;
      fault  <= 1'b0;
      s_q    <= 1'b0;
      size_q <= SZ_BYTE;
      uns_q  <= 1'b0;
      addr_q <= '0;
      din_q  <= '0;
    end else begin
      done <= done_nx;
      cnt  <= (st == FETCH || st == DATA) && !wait_done ? cnt + 4'd1 : 4'd0;
      if (st == IDLE && b.Start) begin
        pc    <= b.Next_PC;
        fault <= 1'b0;
      end
      if (st == FETCH && wait_done) begin
        if (fetch_bad) fault <= 1'b1;
        else iout <= mem[pc[AW+1:2]];
      end
      if (st == EXEC && b.Step && b.Mem_Req) begin
        s_q    <= b.S;
        size_q <= b.Size;
        uns_q  <= b.Unsigned;
        addr_q <= b.Data_Addr[AW+1:0];
        din_q  <= b.Data_In;
      end
      if (st == DATA && wait_done) begin
        if (data_bad) fault <= 1'b1;
        else if (!s_q) mout <= ld;
      end
    end
  end
  // RAM has no reset: an aborted store simply never reaches this write
  always_ff @(posedge Clock) begin
    for (int i = 0; i < 4; i++) if (wr_en && wmask[i]) mem[addr_q[AW+1:2]][8*i +: 8] <= wword[8*i +: 8];
  end
  assign b.PC_out = pc;
  assign b.Iout   = iout;
  assign b.Mout   = mout;
  assign b.E      = st == EXEC;
  assign b.Busy   = st != IDLE;
  assign b.Done   = done;
  assign b.Fault  = fault;
endmodule
